ret_pred_fetch: RTL and testbench
=================================

Name: ret_pred_fetch

Overview:
- Fetch-side consumer of the return address stack. The stack is written from EX on jal/jalr link events; this block reads it from IF.
- Detects return instructions in the fetched word and redirects fetch to the stack's top address.
- Records each return prediction in an in-order pending queue. When EX resolves the return, the block checks the prediction and raises a registered mispredict with the correct target.

Parameters:
- DEPTH, 4, pending-prediction queue entries; power of two, at least 2.
- QIDX, 2, log2(DEPTH); pointer width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- if_valid  in  1  fetched instruction valid this cycle.
- if_instr  in  32  fetched instruction word.
- stall  in  1  pipeline stall; no enqueue while high.
- ras_top  in  32  current top-of-stack address from the RAS.
- ras_empty  in  1  RAS holds no entries.
- ex_ret_valid  in  1  EX resolves the oldest outstanding return this cycle.
- ex_ret_target  in  32  actual jalr target computed in EX.
- flush  in  1  pipeline flush; discard all pending predictions.
- pred_taken  out  1  redirect fetch to pred_target this cycle (combinational).
- pred_target  out  32  predicted return address (combinational).
- fetch_hold  out  1  queue full and a return was fetched; IF must hold.
- mispredict  out  1  registered one-cycle pulse: resolved target differed from the prediction.
- correct_target  out  32  registered; valid while mispredict=1.
- pending_count  out  QIDX+1  registered occupancy of the queue.

Behaviour:
- Return detect, combinational:
  - is_ret = (if_instr[6:0] == 7'b1100111) and rs1 in {x1, x5} and rd not in {x1, x5}.
  - A jalr that both pops and pushes (rd in {x1, x5}) is not treated as a return.
- fetch_hold = if_valid & is_ret & (pending_count == DEPTH).
- An accepted return (enqueue) requires if_valid & is_ret & ~stall & ~fetch_hold.
- On an accepted return:
  - pred_taken = ~ras_empty.
  - pred_target = ras_top when taken, else 0.
  - The entry {taken, target} is written at the tail.
- pred_taken=0 and pred_target=0 in every other case.
- A not-taken entry (RAS was empty) always resolves as a mispredict.
- Resolve: on ex_ret_valid with pending_count>0, pop the head. The following cycle:
  - mispredict=1 if the head was not taken or its target != ex_ret_target.
  - correct_target=ex_ret_target.
- ex_ret_valid with an empty queue is ignored: no pop, no mispredict.
- Full/enqueue: full is evaluated from the registered count only; there is no bypass. An enqueue is refused at DEPTH even if a dequeue occurs in the same cycle.
- Simultaneous enqueue and dequeue: pending_count unchanged; both pointers advance.
- Head/tail pointers are QIDX bits wide and wrap modulo DEPTH.
- Flush:
  - Any resolve in the same cycle is still compared and its mispredict is still issued next cycle, because EX is older than the flush.
  - Then head=tail=0 and pending_count=0.
  - A same-cycle enqueue is dropped, and pred_taken is forced to 0.
- Reset (rst=0, asynchronous):
  - pointers=0, pending_count=0, mispredict=0, correct_target=0, all entry valid bits cleared.
  - Combinational outputs follow from the reset state.
- Latency: prediction 0 cycles after fetch; mispredict 1 cycle after resolve.

Optional Feature:
- Macro: RET_PRED_STATS_EN.
- When defined, adds outputs stat_hits [31:0] and stat_misses [31:0].
  - stat_hits increments on each correct resolve; stat_misses increments on each mispredict.
  - Both saturate at 32'hFFFFFFFF, reset to 0, and are not cleared by flush.
- When not defined, the ports and counters do not exist and behaviour is otherwise identical.

Test Plan:
- Basic hit: reset, then fetch jalr x0,0(x1) (32'h00008067) with ras_top=32'h0000_1004 and ras_empty=0.
  - Required: pred_taken=1, pred_target=32'h1004, pending_count=1.
  - Then ex_ret_valid with target 32'h1004: mispredict stays 0 and pending_count returns to 0.
- Wrong target: same fetch with ras_top=32'h2000, resolve with ex_ret_target=32'h2008.
  - Required: next cycle mispredict=1 for exactly one cycle, correct_target=32'h2008.
- Empty RAS: ras_empty=1 and a return is fetched.
  - Required: pred_taken=0, entry recorded, pending_count=1.
  - Resolve with 32'h3000: mispredict=1, correct_target=32'h3000.
- Full queue: accept 4 returns without resolving (DEPTH=4), then fetch a 5th with ex_ret_valid=1 in the same cycle.
  - Required: fetch_hold=1, pred_taken=0, pending_count goes 4 to 3.
  - Next cycle the same fetch is accepted and pending_count=4.
- Flush with resolve: pending_count=2 with the head predicted 32'h40. Assert flush, ex_ret_valid with target 32'h44, and a new return fetch, all in one cycle.
  - Required: mispredict=1 with correct_target=32'h44 next cycle, pending_count=0, and pred_taken=0 during the flush cycle.
- Reset mid-operation: pending_count=3, then pull rst low between clock edges.
  - Required: pending_count=0 and mispredict=0 immediately, without waiting for a clock edge.
  - A resolve after reset release produces no mispredict.

Source files
------------

// File: rtl/ret_pred_fetch.sv
// Return-address predictor at IF with an in-order pending queue; RET_PRED_STATS_EN adds hit/miss counters.
// Latency: prediction is combinational with fetch; mispredict is registered 1 cycle after EX resolve.
// Backpressure: fetch_hold while the queue is full and a return is fetched; stall blocks enqueue.
module ret_pred_fetch #(
  parameter int DEPTH = 4,
  parameter int QIDX  = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_valid,
  input  logic [31:0]     if_instr,
  input  logic            stall,
  input  logic [31:0]     ras_top,
  input  logic            ras_empty,
  input  logic            ex_ret_valid,
  input  logic [31:0]     ex_ret_target,
  input  logic            flush,
  output logic            pred_taken,
  output logic [31:0]     pred_target,
  output logic            fetch_hold,
  output logic            mispredict,
  output logic [31:0]     correct_target,
  output logic [QIDX:0]   pending_count
`ifdef RET_PRED_STATS_EN
  ,
  output logic [31:0]     stat_hits,
  output logic [31:0]     stat_misses
`endif
);

  typedef struct packed {
    logic        taken;
    logic [31:0] target;
  } pred_ent_t;

  localparam logic [QIDX:0] FULL_CNT = (QIDX+1)'(DEPTH);

  logic [6:0]       opcode;
  logic [4:0]       rd;
  logic [4:0]       rs1;
  logic             rs1_link;
  logic             rd_link;
  logic             is_ret;
  logic             enq;
  logic             deq;
  logic             head_miss;
  logic             unused_instr_bits;
  logic [QIDX-1:0]  head;
  logic [QIDX-1:0]  tail;
  logic [DEPTH-1:0] ent_vld;
  pred_ent_t        ent_q [DEPTH];
  pred_ent_t        head_ent;

  assign opcode            = if_instr[6:0];
  assign rd                = if_instr[11:7];
  assign rs1               = if_instr[19:15];
  assign unused_instr_bits = ^{if_instr[31:20], if_instr[14:12]};

  // A jalr that links through x1/x5 as rd is a coroutine swap, not a plain return.
  assign rs1_link = (rs1 == 5'd1) || (rs1 == 5'd5);
  assign rd_link  = (rd == 5'd1) || (rd == 5'd5);
  assign is_ret   = (opcode == 7'b1100111) && rs1_link && !rd_link;

  assign fetch_hold  = if_valid & is_ret & (pending_count == FULL_CNT);
  assign enq         = if_valid & is_ret & ~stall & ~fetch_hold & ~flush;
  assign pred_taken  = enq & ~ras_empty;
  assign pred_target = pred_taken ? ras_top : 32'd0;

  assign head_ent  = ent_q[head];
  assign deq       = ex_ret_valid & ent_vld[head] & (pending_count != '0);
  assign head_miss = ~head_ent.taken | (head_ent.target != ex_ret_target);

  // Payload carries no reset; only the valid bits define occupancy.
  always_ff @(posedge clk) begin
    if (enq) begin
      ent_q[tail] <= '{taken: pred_taken, target: pred_target};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head           <= '0;
      tail           <= '0;
      pending_count  <= '0;
      ent_vld        <= '0;
      mispredict     <= 1'b0;
      correct_target <= 32'd0;
    end else begin
      // EX is older than the flush, so the resolve is still reported.
      mispredict <= deq & head_miss;
      if (deq) begin
        correct_target <= ex_ret_target;
      end
      if (flush) begin
        head          <= '0;
        tail          <= '0;
        pending_count <= '0;
        ent_vld       <= '0;
      end else begin
        if (enq) begin
          tail          <= tail + 1'b1;
          ent_vld[tail] <= 1'b1;
        end
        if (deq) begin
          head          <= head + 1'b1;
          ent_vld[head] <= 1'b0;
        end
        unique case ({enq, deq})
          2'b10:   pending_count <= pending_count + 1'b1;
          2'b01:   pending_count <= pending_count - 1'b1;
          default: pending_count <= pending_count;
        endcase
      end
    end
  end

`ifdef RET_PRED_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_hits   <= 32'd0;
      stat_misses <= 32'd0;
    end else if (deq) begin
      if (!head_miss && stat_hits != 32'hFFFF_FFFF) begin
        stat_hits <= stat_hits + 32'd1;
      end
      if (head_miss && stat_misses != 32'hFFFF_FFFF) begin
        stat_misses <= stat_misses + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_ret_pred_fetch.sv
// Bench for ret_pred_fetch: directed scenarios plus random traffic against a queue-based reference model.
module tb_ret_pred_fetch;

  localparam int DEPTH = 4;
  localparam int QIDX  = 2;

  logic          clk;
  logic          rst;
  logic          if_valid;
  logic [31:0]   if_instr;
  logic          stall;
  logic [31:0]   ras_top;
  logic          ras_empty;
  logic          ex_ret_valid;
  logic [31:0]   ex_ret_target;
  logic          flush;
  logic          pred_taken;
  logic [31:0]   pred_target;
  logic          fetch_hold;
  logic          mispredict;
  logic [31:0]   correct_target;
  logic [QIDX:0] pending_count;
`ifdef RET_PRED_STATS_EN
  logic [31:0]   stat_hits;
  logic [31:0]   stat_misses;
`endif

  ret_pred_fetch #(.DEPTH(DEPTH), .QIDX(QIDX)) dut (
    .clk            (clk),
    .rst            (rst),
    .if_valid       (if_valid),
    .if_instr       (if_instr),
    .stall          (stall),
    .ras_top        (ras_top),
    .ras_empty      (ras_empty),
    .ex_ret_valid   (ex_ret_valid),
    .ex_ret_target  (ex_ret_target),
    .flush          (flush),
    .pred_taken     (pred_taken),
    .pred_target    (pred_target),
    .fetch_hold     (fetch_hold),
    .mispredict     (mispredict),
    .correct_target (correct_target),
    .pending_count  (pending_count)
`ifdef RET_PRED_STATS_EN
    ,
    .stat_hits      (stat_hits),
    .stat_misses    (stat_misses)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        taken;
    logic [31:0] target;
  } ent_t;

  ent_t        pq[$];
  logic        exp_mis;
  logic [31:0] exp_ct;
  logic [31:0] exp_hits;
  logic [31:0] exp_misses;
  int          n_chk;
  int          n_fail;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, expv, $time);
    end
  endtask

  task automatic clear_in();
    if_valid      = 1'b0;
    if_instr      = 32'h0000_0013;
    stall         = 1'b0;
    ras_top       = 32'd0;
    ras_empty     = 1'b0;
    ex_ret_valid  = 1'b0;
    ex_ret_target = 32'd0;
    flush         = 1'b0;
  endtask

  // One clock cycle: inputs already applied just after a falling edge.
  task automatic step();
    logic [6:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic        is_ret;
    logic        hold;
    logic        acc;
    logic        taken;
    logic        miss;
    ent_t        h;
    #1;
    op     = if_instr[6:0];
    rd     = if_instr[11:7];
    rs1    = if_instr[19:15];
    is_ret = (op == 7'h67) && (rs1 == 5'd1 || rs1 == 5'd5) && !(rd == 5'd1 || rd == 5'd5);
    hold   = if_valid && is_ret && (pq.size() == DEPTH);
    acc    = if_valid && is_ret && !stall && !hold && !flush;
    taken  = acc && !ras_empty;
    chk("fetch_hold", {31'd0, fetch_hold}, {31'd0, hold});
    chk("pred_taken", {31'd0, pred_taken}, {31'd0, taken});
    chk("pred_target", pred_target, taken ? ras_top : 32'd0);
    exp_mis = 1'b0;
    if (ex_ret_valid && pq.size() > 0) begin
      h       = pq.pop_front();
      miss    = !h.taken || (h.target != ex_ret_target);
      exp_mis = miss;
      exp_ct  = ex_ret_target;
      if (miss && exp_misses != 32'hFFFF_FFFF) exp_misses++;
      if (!miss && exp_hits != 32'hFFFF_FFFF) exp_hits++;
    end
    if (flush) pq.delete();
    else if (acc) pq.push_back('{taken, taken ? ras_top : 32'd0});
    @(posedge clk);
    @(negedge clk);
    chk("mispredict", {31'd0, mispredict}, {31'd0, exp_mis});
    if (exp_mis) chk("correct_target", correct_target, exp_ct);
    chk("pending_count", {29'd0, pending_count}, pq.size());
`ifdef RET_PRED_STATS_EN
    chk("stat_hits", stat_hits, exp_hits);
    chk("stat_misses", stat_misses, exp_misses);
`endif
  endtask

  task automatic fetch_ret(input logic [31:0] top, input logic empty);
    clear_in();
    if_valid  = 1'b1;
    if_instr  = 32'h0000_8067;
    ras_top   = top;
    ras_empty = empty;
  endtask

  task automatic do_flush();
    clear_in();
    flush = 1'b1;
    step();
    clear_in();
  endtask

  function automatic logic [4:0] pick_reg();
    case ($urandom_range(3, 0))
      0:       return 5'd0;
      1:       return 5'd1;
      2:       return 5'd5;
      default: return 5'd6;
    endcase
  endfunction

  function automatic logic [31:0] gen_instr();
    logic [11:0] imm;
    if ($urandom_range(9, 0) < 2) return $urandom;
    imm = ($urandom_range(3, 0) == 0) ? 12'($urandom) : 12'd0;
    return {imm, pick_reg(), 3'b000, pick_reg(), 7'h67};
  endfunction

  initial begin
    n_chk      = 0;
    n_fail     = 0;
    exp_mis    = 1'b0;
    exp_ct     = 32'd0;
    exp_hits   = 32'd0;
    exp_misses = 32'd0;
    rst        = 1'b0;
    clear_in();
    #3;
    chk("rst_pending_count", {29'd0, pending_count}, 32'd0);
    chk("rst_mispredict", {31'd0, mispredict}, 32'd0);
    chk("rst_correct_target", correct_target, 32'd0);
    chk("rst_pred_taken", {31'd0, pred_taken}, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Basic hit
    fetch_ret(32'h0000_1004, 1'b0);
    step();
    chk("hit_count", {29'd0, pending_count}, 32'd1);
    clear_in();
    ex_ret_valid  = 1'b1;
    ex_ret_target = 32'h0000_1004;
    step();
    chk("hit_no_mis", {31'd0, mispredict}, 32'd0);

    // Wrong target
    fetch_ret(32'h0000_2000, 1'b0);
    step();
    clear_in();
    ex_ret_valid  = 1'b1;
    ex_ret_target = 32'h0000_2008;
    step();
    chk("wt_mis", {31'd0, mispredict}, 32'd1);
    chk("wt_target", correct_target, 32'h0000_2008);
    clear_in();
    step();
    chk("wt_pulse_end", {31'd0, mispredict}, 32'd0);

    // Empty RAS
    fetch_ret(32'h0000_5555, 1'b1);
    step();
    clear_in();
    ex_ret_valid  = 1'b1;
    ex_ret_target = 32'h0000_3000;
    step();
    chk("empty_ct", correct_target, 32'h0000_3000);

    // Full queue with same-cycle resolve
    for (int i = 0; i < DEPTH; i++) begin
      fetch_ret(32'h100 + 32'(i * 4), 1'b0);
      step();
    end
    fetch_ret(32'h0000_0200, 1'b0);
    ex_ret_valid  = 1'b1;
    ex_ret_target = 32'h0000_0100;
    #1;
    chk("full_hold", {31'd0, fetch_hold}, 32'd1);
    step();
    chk("full_drain", {29'd0, pending_count}, 32'd3);
    fetch_ret(32'h0000_0200, 1'b0);
    step();
    chk("full_refill", {29'd0, pending_count}, 32'd4);
    do_flush();

    // Flush with resolve and fetch in the same cycle
    fetch_ret(32'h0000_0040, 1'b0);
    step();
    fetch_ret(32'h0000_0048, 1'b0);
    step();
    fetch_ret(32'h0000_0060, 1'b0);
    flush         = 1'b1;
    ex_ret_valid  = 1'b1;
    ex_ret_target = 32'h0000_0044;
    step();
    chk("flush_ct", correct_target, 32'h0000_0044);
    chk("flush_count", {29'd0, pending_count}, 32'd0);

    // Random traffic
    for (int n = 0; n < 500; n++) begin
      clear_in();
      if_valid      = ($urandom_range(3, 0) != 0);
      if_instr      = gen_instr();
      stall         = ($urandom_range(4, 0) == 0);
      ras_top       = {$urandom, 2'b00} ^ 32'($urandom_range(255, 0));
      ras_empty     = ($urandom_range(3, 0) == 0);
      ex_ret_valid  = ($urandom_range(2, 0) == 0);
      ex_ret_target = $urandom;
      if (pq.size() > 0 && $urandom_range(1, 0) == 1) ex_ret_target = pq[0].target;
      flush         = ($urandom_range(19, 0) == 0);
      step();
    end

    // Asynchronous reset mid-operation
    do_flush();
    for (int i = 0; i < 3; i++) begin
      fetch_ret(32'h0000_0700 + 32'(i), 1'b0);
      step();
    end
    clear_in();
    #2;
    rst = 1'b0;
    #1;
    chk("arst_count", {29'd0, pending_count}, 32'd0);
    chk("arst_mis", {31'd0, mispredict}, 32'd0);
    pq.delete();
    exp_mis    = 1'b0;
    exp_ct     = 32'd0;
    exp_hits   = 32'd0;
    exp_misses = 32'd0;
    @(posedge clk);
    @(negedge clk);
    rst           = 1'b1;
    ex_ret_valid  = 1'b1;
    ex_ret_target = 32'h0000_0123;
    step();
    chk("post_rst_no_mis", {31'd0, mispredict}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
